// File: rtl/micron_ctrl_phy_alt_mem_phy_pll_phs_shft.sv
// PLL dynamic phase-shift controller.
// Converts single-step phase-shift requests from the PHY sequencer into the
// Stratix III PLL phasecounterselect/phaseupdown/phasestep/phasedone
// handshake, tracks the absolute resync-clock phase and flags handshake
// timeouts or lock loss.
//
// Ports:
//   seq_clk, reset_seq            clock, async active-high reset
//   pll_locked                    PLL lock (async, synchronised here)
//   seq_pll_start_reconfig        step request (level, sampled in IDLE)
//   seq_pll_select/_inc_dec_n     counter to step and direction (1 = inc)
//   phs_shft_busy                 high while a request cannot be accepted
//   pll_phasecounterselect/updown/phasestep  handshake outputs to the PLL
//   pll_phasedone                 active-low done from PLL (async)
//   resync_phase                  resync clock phase position
//   phs_shft_step_done            one-cycle pulse per successful step
//   phs_shft_timeout_err          sticky timeout / lock-loss flag
//
// state     | meaning
// ----------+-------------------------------------------------------
// INIT      | waiting for synchronised PLL lock, busy
// IDLE      | ready, accepts a request
// SETUP     | select/updown settling before phasestep
// STEP      | phasestep asserted
// WAIT_LOW  | waiting for phasedone to fall
// WAIT_HIGH | waiting for phasedone to rise
// HOLDOFF   | quiet period before returning to IDLE (or INIT on lock loss)
module micron_ctrl_phy_alt_mem_phy_pll_phs_shft #(
    parameter int CLOCK_INDEX_WIDTH   = 4,
    parameter int PLL_STEPS_PER_CYCLE = 48,
    parameter int PHASE_CNT_WIDTH     = 6,
    parameter logic [CLOCK_INDEX_WIDTH-1:0] RESYNC_CLK_INDEX = CLOCK_INDEX_WIDTH'(5),
    parameter int RESYNC_PHASE_INIT   = 0,
    parameter int SETUP_CYCLES        = 2,
    parameter int STEP_CYCLES         = 2,
    parameter int HOLDOFF_CYCLES      = 4,
    parameter int TIMEOUT_CYCLES      = 255
) (
    input  logic                         seq_clk,
    input  logic                         reset_seq,
    input  logic                         pll_locked,
    input  logic                         seq_pll_start_reconfig,
    input  logic [CLOCK_INDEX_WIDTH-1:0] seq_pll_select,
    input  logic                         seq_pll_inc_dec_n,
    output logic                         phs_shft_busy,
    output logic [CLOCK_INDEX_WIDTH-1:0] pll_phasecounterselect,
    output logic                         pll_phaseupdown,
    output logic                         pll_phasestep,
    input  logic                         pll_phasedone,
    output logic [PHASE_CNT_WIDTH-1:0]   resync_phase,
    output logic                         phs_shft_step_done,
    output logic                         phs_shft_timeout_err
);

    localparam int TMR_W = 8;
    localparam logic [PHASE_CNT_WIDTH-1:0] PHASE_MAX  = PHASE_CNT_WIDTH'(PLL_STEPS_PER_CYCLE - 1);
    localparam logic [PHASE_CNT_WIDTH-1:0] PHASE_RST  = PHASE_CNT_WIDTH'(RESYNC_PHASE_INIT);
    // SETUP lasts one extra cycle beyond SETUP_CYCLES: the acceptance cycle
    // in which select/updown are first driven counts as the latch cycle.
    localparam logic [TMR_W-1:0] LD_SETUP   = TMR_W'(SETUP_CYCLES);
    localparam logic [TMR_W-1:0] LD_STEP    = TMR_W'(STEP_CYCLES - 1);
    localparam logic [TMR_W-1:0] LD_WAIT    = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] LD_HOLDOFF = TMR_W'(HOLDOFF_CYCLES - 1);

    typedef enum logic [2:0] {
        INIT, IDLE, SETUP, STEP, WAIT_LOW, WAIT_HIGH, HOLDOFF
    } state_t;

    state_t            state, state_nxt;
    logic [TMR_W-1:0]  tmr, tmr_nxt;
    logic              to_init, to_init_nxt;
    logic              accept, done_evt, tmo_evt;
    logic              locked_s1, locked_s;
    logic              done_s1, done_s;

    // phasedone idles high, so its synchroniser resets to 1
    always_ff @(posedge seq_clk or posedge reset_seq) begin
        if (reset_seq) begin
            locked_s1 <= 1'b0;
            locked_s  <= 1'b0;
            done_s1   <= 1'b1;
            done_s    <= 1'b1;
        end else begin
            locked_s1 <= pll_locked;
            locked_s  <= locked_s1;
            done_s1   <= pll_phasedone;
            done_s    <= done_s1;
        end
    end

    always_ff @(posedge seq_clk or posedge reset_seq) begin
        if (reset_seq) begin
            state   <= INIT;
            tmr     <= '0;
            to_init <= 1'b0;
        end else begin
            state   <= state_nxt;
            tmr     <= tmr_nxt;
            to_init <= to_init_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        tmr_nxt     = (tmr != '0) ? tmr - 1'b1 : tmr;
        to_init_nxt = to_init;
        accept      = 1'b0;
        done_evt    = 1'b0;
        tmo_evt     = 1'b0;

        case (state)
            INIT: begin
                to_init_nxt = 1'b0;
                if (locked_s) state_nxt = IDLE;
            end
            IDLE: begin
                if (seq_pll_start_reconfig) begin
                    accept    = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: if (tmr == '0) state_nxt = STEP;
            STEP:  if (tmr == '0) state_nxt = WAIT_LOW;
            WAIT_LOW: begin
                if (!done_s) begin
                    state_nxt = WAIT_HIGH;
                end else if (tmr == '0) begin
                    tmo_evt   = 1'b1;
                    state_nxt = HOLDOFF;
                end
            end
            WAIT_HIGH: begin
                if (done_s) begin
                    done_evt  = 1'b1;
                    state_nxt = HOLDOFF;
                end else if (tmr == '0) begin
                    tmo_evt   = 1'b1;
                    state_nxt = HOLDOFF;
                end
            end
            HOLDOFF: if (tmr == '0) state_nxt = to_init ? INIT : IDLE;
            default: state_nxt = INIT;
        endcase

        // Lock loss anywhere past INIT is treated like a timeout, and the
        // holdoff then falls back to INIT to wait for relock.
        if (state != INIT && !locked_s) begin
            tmo_evt     = 1'b1;
            to_init_nxt = 1'b1;
            accept      = 1'b0;
            done_evt    = 1'b0;
            if (state != HOLDOFF) state_nxt = HOLDOFF;
            else if (tmr == '0)   state_nxt = INIT;
        end

        // WAIT_LOW -> WAIT_HIGH is a state change, so the wait timer reloads
        if (state_nxt != state) begin
            case (state_nxt)
                SETUP:               tmr_nxt = LD_SETUP;
                STEP:                tmr_nxt = LD_STEP;
                WAIT_LOW, WAIT_HIGH: tmr_nxt = LD_WAIT;
                HOLDOFF:             tmr_nxt = LD_HOLDOFF;
                default:             tmr_nxt = '0;
            endcase
        end
    end

    always_ff @(posedge seq_clk or posedge reset_seq) begin
        if (reset_seq) begin
            phs_shft_busy          <= 1'b1;
            pll_phasestep          <= 1'b0;
            pll_phaseupdown        <= 1'b0;
            pll_phasecounterselect <= '0;
            resync_phase           <= PHASE_RST;
            phs_shft_step_done     <= 1'b0;
            phs_shft_timeout_err   <= 1'b0;
        end else begin
            phs_shft_busy      <= (state_nxt != IDLE);
            pll_phasestep      <= (state_nxt == STEP);
            phs_shft_step_done <= done_evt;
            if (tmo_evt) phs_shft_timeout_err <= 1'b1;
            if (accept) begin
                pll_phasecounterselect <= seq_pll_select;
                pll_phaseupdown        <= seq_pll_inc_dec_n;
            end
            if (done_evt && pll_phasecounterselect == RESYNC_CLK_INDEX) begin
                if (pll_phaseupdown)
                    resync_phase <= (resync_phase == PHASE_MAX) ? '0 : resync_phase + 1'b1;
                else
                    resync_phase <= (resync_phase == '0) ? PHASE_MAX : resync_phase - 1'b1;
            end
        end
    end

endmodule

// File: doc/micron_ctrl_phy_alt_mem_phy_pll_phs_shft.md
Name: micron_ctrl_phy_alt_mem_phy_pll_phs_shft

Overview:
- Downstream of the PHY sequencer.
- Converts the sequencer's single-step PLL phase-shift requests (start/select/direction) into the Stratix III PLL dynamic phase-shift handshake (phasecounterselect/phaseupdown/phasestep/phasedone).
- Returns phs_shft_busy to the sequencer.
- Tracks the absolute resync-clock phase position and flags handshake timeouts.

Parameters:
- CLOCK_INDEX_WIDTH, 4, width of the PLL counter select.
- PLL_STEPS_PER_CYCLE, 48, phase steps per clock period; wrap modulus for the position counter.
- PHASE_CNT_WIDTH, 6, width of resync_phase; must satisfy 2^PHASE_CNT_WIDTH >= PLL_STEPS_PER_CYCLE.
- RESYNC_CLK_INDEX, 4'd5, counter index whose steps update resync_phase.
- RESYNC_PHASE_INIT, 0, reset value of resync_phase.
- SETUP_CYCLES, 2, cycles select/updown are held stable before phasestep.
- STEP_CYCLES, 2, phasestep high duration.
- HOLDOFF_CYCLES, 4, idle cycles after completion before busy drops.
- TIMEOUT_CYCLES, 255, maximum wait per phasedone edge; 8-bit counter.

Ports:
- seq_clk  in  1  sequencer/reconfig clock.
- reset_seq  in  1  asynchronous, active-high reset.
- pll_locked  in  1  PLL lock, asynchronous; 2-flop synchronised.
- seq_pll_start_reconfig  in  1  step request from sequencer (level; sampled in IDLE only).
- seq_pll_select  in  CLOCK_INDEX_WIDTH  PLL counter to step.
- seq_pll_inc_dec_n  in  1  1 = increment phase, 0 = decrement.
- phs_shft_busy  out  1  high while not ready to accept a request.
- pll_phasecounterselect  out  CLOCK_INDEX_WIDTH  to PLL.
- pll_phaseupdown  out  1  to PLL.
- pll_phasestep  out  1  to PLL.
- pll_phasedone  in  1  from PLL, active-low done, asynchronous; 2-flop synchronised (phasedone_s).
- resync_phase  out  PHASE_CNT_WIDTH  current resync clock phase position.
- phs_shft_step_done  out  1  one-cycle pulse on successful step completion.
- phs_shft_timeout_err  out  1  sticky timeout flag, cleared only by reset.

Behaviour:

Reset values:
- state = INIT, phs_shft_busy = 1, pll_phasestep = 0, pll_phaseupdown = 0, pll_phasecounterselect = 0.
- resync_phase = RESYNC_PHASE_INIT, phs_shft_step_done = 0, phs_shft_timeout_err = 0.
- Synchroniser flops: pll_locked sync = 0, phasedone sync = 1.

States:
- INIT: busy = 1. Advance to IDLE when synced pll_locked = 1. Busy drops 1 cycle after the transition.
- IDLE: busy = 0. If seq_pll_start_reconfig = 1 and synced pll_locked = 1:
  - latch select and direction into pll_phasecounterselect / pll_phaseupdown;
  - busy = 1 on the next edge;
  - go to SETUP.
  - Requests while busy = 1 are ignored.
- SETUP: hold SETUP_CYCLES cycles with phasestep = 0, then STEP.
- STEP: phasestep = 1 for exactly STEP_CYCLES cycles, then WAIT_LOW with phasestep = 0.
- WAIT_LOW: wait for phasedone_s = 0, then WAIT_HIGH.
- WAIT_HIGH: wait for phasedone_s = 1, then:
  - pulse phs_shft_step_done;
  - update resync_phase;
  - go to HOLDOFF.
- HOLDOFF: HOLDOFF_CYCLES cycles, then IDLE; busy = 0 the first cycle in IDLE.

Timeout and lock loss:
- Wait counter clears on entry to each of WAIT_LOW and WAIT_HIGH.
- If it reaches TIMEOUT_CYCLES without the awaited level:
  - set phs_shft_timeout_err;
  - no resync_phase update and no step_done;
  - go to HOLDOFF.
- Synced pll_locked = 0 in any state other than INIT takes the timeout path, setting err; HOLDOFF then returns to INIT rather than IDLE.

Phase arithmetic:
- resync_phase updates only when the latched select = RESYNC_CLK_INDEX.
- Increment: 47 -> 0 wraps (PLL_STEPS_PER_CYCLE-1 -> 0).
- Decrement: 0 -> PLL_STEPS_PER_CYCLE-1.
- Arithmetic is modular, never saturating.

Latency:
- Request accepted at edge N: phasestep rises at N+1+SETUP_CYCLES.
- Busy-high duration = 1 + SETUP_CYCLES + STEP_CYCLES + wait cycles + HOLDOFF_CYCLES.

Output stability:
- Select and updown outputs are stable from SETUP through HOLDOFF.
- A change on seq_pll_select mid-operation has no effect.

Asynchronous reset mid-operation:
- All registers return immediately to reset values, including phasestep = 0.
- PLL phasedone state is not awaited.

Test Plan:
1. Reset release, pll_locked high after 10 cycles -> busy stays 1 through INIT; busy = 0 three cycles after lock (2 sync + 1).
2. Request select = 5, inc = 1, resync_phase = 47; PLL model drops phasedone 3 cycles after phasestep and raises it 4 later -> phasestep high 2 cycles, starting 3 cycles after acceptance; step_done pulse; resync_phase = 0; busy low 4 cycles after step_done.
3. Request select = 5, dec, from resync_phase = 0 -> resync_phase = 47. Request select = 2 -> resync_phase unchanged, step_done still pulses.
4. PLL model never drops phasedone -> after 255 wait cycles phs_shft_timeout_err = 1, no step_done, busy returns to 0 after holdoff. A subsequent good step succeeds with err still 1.
5. Toggle seq_pll_select and hold start_reconfig high while busy -> select output unchanged, exactly one step per IDLE acceptance.
6. Deassert pll_locked during WAIT_HIGH -> err = 1, FSM returns to INIT, busy stays 1 until lock regained. Assert reset_seq during STEP -> phasestep = 0 and busy = 1 immediately (asynchronous).
